lcd_sched: RTL and testbench
============================

# lcd_sched

Two-requester command scheduler that sits in front of the LCD 1602A controller and is the only block driving its command and data inputs. It runs the power-up INIT automatically after reset. It buffers CLEAR and WRITE-character requests from two independent clients in per-client 4-deep FIFOs, arbitrates between them, and presents one controller command at a time. Each command is held until the controller reports ready, with a mandatory IDLE gap between commands.

## Interface
- `HOLD`, 2: cycles after a new command is presented during which `ctrl_rdy` is ignored (covers the controller's stale ready).
- `GAP`, 2: IDLE cycles driven between consecutive commands (minimum 1).
- `TIMEOUT`, 200000: cycles a command may wait for `ctrl_rdy` before it is abandoned.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: client request strobe.
- `req0_op` / `req1_op` in 1: 0 = CLEAR, 1 = WRITE.
- `req0_data` / `req1_data` in 8: character code; ignored for CLEAR.
- `req0_ready` / `req1_ready` out 1: FIFO not full.
- `ctrl_rdy` in 1: controller done with the presented command.
- `cmd_out` out 6: controller command index. INIT=0, SEND_DATA=2, CLEAR=3, IDLE=6.
- `data_out` out 8: character for SEND_DATA.
- `init_done` out 1: boot INIT completed.
- `busy` out 1: a command is in progress or queued.
- `grant_id` out 1: client of the command currently or last issued.
- `err_timeout` out 1: sticky timeout flag.

## Operation
- Reset values:
  - `cmd_out` = 6; `data_out` = 0.
  - `init_done` = 0; `busy` = 1; `err_timeout` = 0.
  - `grant_id` = 1 (so client 0 wins first); both FIFOs empty.
  - `reqN_ready` = 1; state = BOOT.
- FIFOs:
  - Entry is 9 bits {op, data}, depth 4, 3-bit count.
  - Push when `reqN_valid & reqN_ready`; push while full is impossible (ready low).
  - Pop happens only in ARB.
  - Simultaneous push and pop: count unchanged, order preserved.
- States:
  - BOOT:
    - `cmd_out`=0; hold counter loads `HOLD`.
    - When the counter reaches 0 and `ctrl_rdy`=1: set `init_done`, go to GAP.
  - GAP:
    - `cmd_out`=6 for `GAP` cycles, then go to ARB.
  - ARB:
    - `cmd_out`=6.
    - Neither FIFO non-empty: stay in ARB, `busy`=0.
    - Exactly one FIFO non-empty: grant it.
    - Both non-empty: arbitration rule per Configuration.
    - On grant: pop the head, latch op/data, update `grant_id`, go to ISSUE.
  - ISSUE:
    - `cmd_out` = 2 (WRITE) or 3 (CLEAR); `data_out` = latched data, held stable.
    - After `HOLD` cycles, `ctrl_rdy`=1 causes a transition to GAP.
  - Timeout (BOOT or ISSUE): a wait counter starts at 0 on state entry. On reaching `TIMEOUT`-1 without ready:
    - Set `err_timeout`.
    - Drop the command; go to GAP.
    - `init_done` remains 0 if the timeout occurred in BOOT.
- Client requests are accepted into the FIFOs during BOOT but are not issued until `init_done`=1.
- `busy` = 0 only in ARB with both FIFOs empty.
- `rst` asserted mid-command:
  - Next edge: state returns to BOOT and `cmd_out` = 6 for that one cycle.
  - FIFOs are flushed; `err_timeout` is cleared.
  - INIT then reruns.

## Timing
- All outputs are registered, except `reqN_ready` = (count != 4), which is combinational from the FIFO count.
- Latency from request to command, with the scheduler idle in ARB:
  - push at edge N;
  - ARB grants at edge N+1;
  - `cmd_out` becomes 2/3 after edge N+2.
- Earliest completion:
  - `ctrl_rdy` is sampled first `HOLD` cycles after entering ISSUE.
  - After `ctrl_rdy` is sampled: `GAP` IDLE cycles, then one ARB cycle.
  - Back-to-back command spacing is therefore ≥ `HOLD`+`GAP`+2 cycles.
- `data_out` changes only on entry to ISSUE.

## Configuration
- `LCD_SCHED_RR_EN` defined:
  - Round-robin arbitration.
  - When both FIFOs are non-empty, grant the client ≠ `grant_id`.
- `LCD_SCHED_RR_EN` undefined:
  - Fixed priority; client 0 always wins ties.
  - Client 1 may starve.

## Test plan
- Reset, `ctrl_rdy` pulses 10 cycles after INIT is presented:
  - `cmd_out`=0 until that pulse, then 6 for 2 cycles.
  - `init_done`=1; `busy`=0.
- Client 0 pushes WRITE 0x41 while idle:
  - `cmd_out`=2 and `data_out`=0x41 two cycles after the push.
  - Held until `ctrl_rdy`, then `cmd_out`=6; `grant_id`=0.
- Client 0 pushes 5 WRITEs back-to-back while the controller is stalled:
  - 4 are accepted; `req0_ready`=0 after the 4th.
  - After the first issue, `req0_ready` rises once the head is popped.
- Both clients push 2 WRITEs each (0x10, 0x11 / 0x20, 0x21) in the same cycles:
  - With `LCD_SCHED_RR_EN`: issue order 0x10, 0x20, 0x11, 0x21.
  - Without it: order 0x10, 0x11, 0x20, 0x21.
- CLEAR issued, `ctrl_rdy` held low, `TIMEOUT`=50:
  - `err_timeout`=1 exactly 50 cycles after ISSUE entry.
  - `cmd_out`=6; the next queued request is issued.
- `rst` pulsed while a WRITE is in ISSUE with 3 entries queued:
  - `cmd_out`=0 (INIT) re-presented.
  - Queue empty; `init_done`=0; `err_timeout`=0.

Source files
------------

// File: rtl/lcd_sched_if.sv
// rtl/lcd_sched_if.sv - client request and controller command signals of lcd_sched
// Ports:
//   reqN_valid/op/data : client strobe, 0=CLEAR 1=WRITE, character code
//   reqN_ready         : client FIFO not full
//   ctrl_rdy           : controller finished the presented command
//   cmd_out/data_out   : command index and character to the controller
// Modports: master = clients plus controller, slave = lcd_sched.
interface lcd_sched_if;
  logic       req0_valid;
  logic       req0_op;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_op;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       ctrl_rdy;
  logic [5:0] cmd_out;
  logic [7:0] data_out;

  modport master (
    output req0_valid, req0_op, req0_data,
    input  req0_ready,
    output req1_valid, req1_op, req1_data,
    input  req1_ready,
    output ctrl_rdy,
    input  cmd_out, data_out
  );

  modport slave (
    input  req0_valid, req0_op, req0_data,
    output req0_ready,
    input  req1_valid, req1_op, req1_data,
    output req1_ready,
    input  ctrl_rdy,
    output cmd_out, data_out
  );
endinterface

// File: rtl/lcd_sched.sv
// rtl/lcd_sched.sv - two-client command scheduler in front of the LCD 1602A controller
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : lcd_sched_if.slave (client requests, ctrl_rdy, cmd_out, data_out)
//   init_done   : boot INIT completed
//   busy        : command in progress or queued
//   grant_id    : client of the command currently or last issued
//   err_timeout : sticky, a command waited TIMEOUT cycles for ctrl_rdy
// Build option: LCD_SCHED_RR_EN selects round-robin arbitration, otherwise
// client 0 has fixed priority.
module lcd_sched #(
  parameter int HOLD    = 2,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        rst,
  lcd_sched_if.slave  bus,
  output logic        init_done,
  output logic        busy,
  output logic        grant_id,
  output logic        err_timeout
);

  localparam logic [5:0] CMD_INIT  = 6'd0;
  localparam logic [5:0] CMD_SEND  = 6'd2;
  localparam logic [5:0] CMD_CLEAR = 6'd3;
  localparam logic [5:0] CMD_IDLE  = 6'd6;

  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // BOOT loads HOLD on the reset edge, one edge before INIT appears; ISSUE
  // loads on the same edge the command appears, hence one less.
  localparam int HOLD_ISSUE = (HOLD > 0) ? HOLD - 1 : 0;

  typedef enum logic [2:0] {S_BOOT, S_GAP, S_ARB, S_GRANT, S_ISSUE} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wait_cnt;
  logic          op_q;
  logic [7:0]    data_q;

  // Per-client FIFOs: 4 x {op, data}
  logic [8:0] mem0 [4];
  logic [8:0] mem1 [4];
  logic [1:0] wp0, rp0, wp1, rp1;
  logic [2:0] cnt0, cnt1;
  logic [2:0] cnt0_nxt, cnt1_nxt;
  logic       push0, push1, pop0, pop1;
  logic       grant_any, sel1;
  logic [8:0] head;

  assign bus.req0_ready = (cnt0 != 3'd4);
  assign bus.req1_ready = (cnt1 != 3'd4);
  assign push0 = bus.req0_valid & bus.req0_ready;
  assign push1 = bus.req1_valid & bus.req1_ready;

  assign grant_any = (state == S_ARB) && init_done && ((cnt0 != 3'd0) || (cnt1 != 3'd0));

`ifdef LCD_SCHED_RR_EN
  // Tie goes to the client that was not granted last.
  assign sel1 = (cnt1 != 3'd0) && ((cnt0 == 3'd0) || (grant_id == 1'b0));
`else
  assign sel1 = (cnt1 != 3'd0) && (cnt0 == 3'd0);
`endif

  assign pop0 = grant_any & ~sel1;
  assign pop1 = grant_any & sel1;
  assign head = sel1 ? mem1[rp1] : mem0[rp0];

  assign cnt0_nxt = cnt0 + {2'b00, push0} - {2'b00, pop0};
  assign cnt1_nxt = cnt1 + {2'b00, push1} - {2'b00, pop1};

  always_ff @(posedge clk) begin
    if (push0) mem0[wp0] <= {bus.req0_op, bus.req0_data};
    if (push1) mem1[wp1] <= {bus.req1_op, bus.req1_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp0  <= 2'd0;
      rp0  <= 2'd0;
      cnt0 <= 3'd0;
      wp1  <= 2'd0;
      rp1  <= 2'd0;
      cnt1 <= 3'd0;
    end else begin
      if (push0) wp0 <= wp0 + 2'd1;
      if (pop0)  rp0 <= rp0 + 2'd1;
      if (push1) wp1 <= wp1 + 2'd1;
      if (pop1)  rp1 <= rp1 + 2'd1;
      cnt0 <= cnt0_nxt;
      cnt1 <= cnt1_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_BOOT;
      bus.cmd_out  <= CMD_IDLE;
      bus.data_out <= 8'd0;
      init_done    <= 1'b0;
      busy         <= 1'b1;
      grant_id     <= 1'b1;
      err_timeout  <= 1'b0;
      hold_cnt     <= HW'(HOLD);
      gap_cnt      <= '0;
      wait_cnt     <= '0;
      op_q         <= 1'b0;
      data_q       <= 8'd0;
    end else begin
      case (state)
        S_BOOT: begin
          bus.cmd_out <= CMD_INIT;
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == '0 && bus.ctrl_rdy) begin
            init_done   <= 1'b1;
            bus.cmd_out <= CMD_IDLE;
            gap_cnt     <= GW'(GAP - 1);
            state       <= S_GAP;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            bus.cmd_out <= CMD_IDLE;
            gap_cnt     <= GW'(GAP - 1);
            state       <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_GAP: begin
          bus.cmd_out <= CMD_IDLE;
          if (gap_cnt == '0) begin
            state <= S_ARB;
            busy  <= (cnt0_nxt != 3'd0) || (cnt1_nxt != 3'd0);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        S_ARB: begin
          bus.cmd_out <= CMD_IDLE;
          if (grant_any) begin
            op_q     <= head[8];
            data_q   <= head[7:0];
            grant_id <= sel1;
            busy     <= 1'b1;
            state    <= S_GRANT;
          end else begin
            busy <= (cnt0_nxt != 3'd0) || (cnt1_nxt != 3'd0);
          end
        end

        // Grant cycle: the popped command is presented on the next edge,
        // which is where ISSUE timing (hold and timeout) starts.
        S_GRANT: begin
          bus.cmd_out  <= op_q ? CMD_SEND : CMD_CLEAR;
          bus.data_out <= data_q;
          hold_cnt     <= HW'(HOLD_ISSUE);
          wait_cnt     <= '0;
          state        <= S_ISSUE;
        end

        S_ISSUE: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == '0 && bus.ctrl_rdy) begin
            bus.cmd_out <= CMD_IDLE;
            gap_cnt     <= GW'(GAP - 1);
            state       <= S_GAP;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            bus.cmd_out <= CMD_IDLE;
            gap_cnt     <= GW'(GAP - 1);
            state       <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          bus.cmd_out <= CMD_IDLE;
          state       <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sched.sv
// tb/tb_lcd_sched.sv - directed self-checking bench for lcd_sched
module tb_lcd_sched;
  logic clk = 1'b0;
  logic rst;
  logic init_done, busy, grant_id, err_timeout;
  int   checks = 0;
  int   errors = 0;

  lcd_sched_if bus();

  lcd_sched #(.HOLD(2), .GAP(2), .TIMEOUT(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .init_done   (init_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller stand-in: wait for a SEND/CLEAR, capture it, answer after dly cycles.
  task automatic serve(input int dly, output logic [5:0] c, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    c  = 6'd0;
    d  = 8'd0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.cmd_out == 6'd2 || bus.cmd_out == 6'd3) ok = 1'b1;
      else tick();
    end
    if (ok) begin
      c = bus.cmd_out;
      d = bus.data_out;
      repeat (dly) tick();
      bus.ctrl_rdy = 1'b1;
      tick();
      bus.ctrl_rdy = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ctrl_rdy = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_data = 8'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_data = 8'd0;
    repeat (3) tick();
    checks++; if (bus.cmd_out !== 6'd6) begin errors++; $display("FAIL reset_cmd: got %0d expected 6", bus.cmd_out); end
    checks++; if (bus.data_out !== 8'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.data_out); end
    checks++; if ({init_done, busy, grant_id, err_timeout} !== 4'b0110) begin errors++; $display("FAIL reset_flags: got %b expected 0110", {init_done, busy, grant_id, err_timeout}); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.cmd_out !== 6'd0) begin errors++; $display("FAIL boot_init_cmd[%0d]: got %0d expected 0", i, bus.cmd_out); end
    end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL boot_not_done: got %b expected 0", init_done); end
    bus.ctrl_rdy = 1'b1;
    tick();
    bus.ctrl_rdy = 1'b0;
    checks++; if (bus.cmd_out !== 6'd6 || init_done !== 1'b1) begin errors++; $display("FAIL boot_done: cmd %0d init_done %b expected 6 1", bus.cmd_out, init_done); end
    tick();
    checks++; if (bus.cmd_out !== 6'd6) begin errors++; $display("FAIL boot_gap: got %0d expected 6", bus.cmd_out); end
    tick();
    checks++; if (busy !== 1'b0 || bus.cmd_out !== 6'd6) begin errors++; $display("FAIL boot_idle: busy %b cmd %0d expected 0 6", busy, bus.cmd_out); end
  endtask

  task automatic test_arbitration();
    logic [7:0] exp_q [4];
    logic [5:0] c;
    logic [7:0] d;
    bit         ok;
`ifdef LCD_SCHED_RR_EN
    exp_q[0] = 8'h10; exp_q[1] = 8'h20; exp_q[2] = 8'h11; exp_q[3] = 8'h21;
`else
    exp_q[0] = 8'h10; exp_q[1] = 8'h11; exp_q[2] = 8'h20; exp_q[3] = 8'h21;
`endif
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_data = 8'h10;
    bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_data = 8'h20;
    tick();
    bus.req0_data = 8'h11;
    bus.req1_data = 8'h21;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      serve(2, c, d, ok);
      checks++; if (!ok || c !== 6'd2 || d !== exp_q[k]) begin errors++; $display("FAIL arb_order[%0d]: seen %b cmd %0d data %0h expected cmd 2 data %0h", k, ok, c, d, exp_q[k]); end
    end
    wait_idle(ok);
    checks++; if (!ok || grant_id !== 1'b1) begin errors++; $display("FAIL arb_idle: idle %b grant_id %b expected 1 1", ok, grant_id); end
  endtask

  task automatic test_single_write();
    bit ok;
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_data = 8'h41;
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.cmd_out !== 6'd6) begin errors++; $display("FAIL wr_push_cmd: got %0d expected 6", bus.cmd_out); end
    tick();
    checks++; if (bus.cmd_out !== 6'd6) begin errors++; $display("FAIL wr_grant_cmd: got %0d expected 6", bus.cmd_out); end
    tick();
    checks++; if (bus.cmd_out !== 6'd2 || bus.data_out !== 8'h41 || grant_id !== 1'b0) begin errors++; $display("FAIL wr_issue: cmd %0d data %0h grant %b expected 2 41 0", bus.cmd_out, bus.data_out, grant_id); end
    repeat (2) tick();
    checks++; if (bus.cmd_out !== 6'd2 || bus.data_out !== 8'h41) begin errors++; $display("FAIL wr_hold: cmd %0d data %0h expected 2 41", bus.cmd_out, bus.data_out); end
    bus.ctrl_rdy = 1'b1;
    tick();
    bus.ctrl_rdy = 1'b0;
    checks++; if (bus.cmd_out !== 6'd6 || grant_id !== 1'b0) begin errors++; $display("FAIL wr_done: cmd %0d grant %b expected 6 0", bus.cmd_out, grant_id); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_fifo_full();
    logic [5:0] c;
    logic [7:0] d;
    bit         ok;
    logic       exp_rdy;
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_data = 8'h50;
    tick();
    bus.req0_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.cmd_out == 6'd2) ok = 1'b1;
    end
    checks++; if (!ok || bus.data_out !== 8'h50) begin errors++; $display("FAIL full_first_issue: seen %b data %0h expected 1 50", ok, bus.data_out); end
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req0_data = 8'h51 + 8'(i);
      exp_rdy = (i < 4);
      checks++; if (bus.req0_ready !== exp_rdy) begin errors++; $display("FAIL full_ready[%0d]: got %b expected %b", i, bus.req0_ready, exp_rdy); end
      tick();
    end
    bus.req0_valid = 1'b0;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", bus.req0_ready); end
    bus.ctrl_rdy = 1'b1;
    tick();
    bus.ctrl_rdy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.req0_ready == 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL full_ready_rise: got %b expected 1", bus.req0_ready); end
    for (int k = 0; k < 4; k++) begin
      serve(2, c, d, ok);
      checks++; if (!ok || c !== 6'd2 || d !== 8'h51 + 8'(k)) begin errors++; $display("FAIL full_drain[%0d]: seen %b cmd %0d data %0h expected cmd 2 data %0h", k, ok, c, d, 8'h51 + 8'(k)); end
    end
    repeat (10) tick();
    checks++; if (busy !== 1'b0 || bus.cmd_out !== 6'd6) begin errors++; $display("FAIL full_no_fifth: busy %b cmd %0d expected 0 6", busy, bus.cmd_out); end
  endtask

  task automatic test_timeout();
    logic [5:0] c;
    logic [7:0] d;
    bit         ok;
    bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_data = 8'h99;
    tick();
    bus.req0_op = 1'b1; bus.req0_data = 8'h77;
    tick();
    bus.req0_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.cmd_out == 6'd3) ok = 1'b1;
      else tick();
    end
    checks++; if (!ok || err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear_issue: seen %b err %b expected 1 0", ok, err_timeout); end
    repeat (49) tick();
    checks++; if (err_timeout !== 1'b0 || bus.cmd_out !== 6'd3) begin errors++; $display("FAIL to_before: err %b cmd %0d expected 0 3", err_timeout, bus.cmd_out); end
    tick();
    checks++; if (err_timeout !== 1'b1 || bus.cmd_out !== 6'd6) begin errors++; $display("FAIL to_fire: err %b cmd %0d expected 1 6", err_timeout, bus.cmd_out); end
    serve(2, c, d, ok);
    checks++; if (!ok || c !== 6'd2 || d !== 8'h77) begin errors++; $display("FAIL to_next: seen %b cmd %0d data %0h expected cmd 2 data 77", ok, c, d); end
    wait_idle(ok);
    checks++; if (!ok || err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: idle %b err %b expected 1 1", ok, err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_data = 8'h60;
    tick();
    bus.req0_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.cmd_out == 6'd2) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_issue: cmd %0d expected 2", bus.cmd_out); end
    bus.req0_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      bus.req0_data = 8'h60 + 8'(i);
      tick();
    end
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.cmd_out !== 6'd6 || init_done !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reset: cmd %0d init %b err %b busy %b expected 6 0 0 1", bus.cmd_out, init_done, err_timeout, busy); end
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_flush_ready: got %b expected 1", bus.req0_ready); end
    tick();
    checks++; if (bus.cmd_out !== 6'd0) begin errors++; $display("FAIL mid_reinit: got %0d expected 0", bus.cmd_out); end
    tick();
    bus.ctrl_rdy = 1'b1;
    tick();
    bus.ctrl_rdy = 1'b0;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_init_done: got %b expected 1", init_done); end
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || bus.cmd_out !== 6'd6) begin errors++; $display("FAIL mid_queue_empty: busy %b cmd %0d expected 0 6", busy, bus.cmd_out); end
    repeat (6) tick();
    checks++; if (bus.cmd_out !== 6'd6 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_stale: cmd %0d busy %b expected 6 0", bus.cmd_out, busy); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_write();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
